// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor in WIDTH+1 bits, keep the difference only when it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_i, dvd_bit_i};
  // rem < divisor always holds, so the top bit of trial is a reliable sign.
  assign trial   = shifted - {1'b0, divisor_i};
  assign q_o     = ~trial[WIDTH];
  assign rem_o   = q_o ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div32_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional signed mode is enabled by defining DIV32_SIGNED_EN.
module div32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV32_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   remd_q, remd_d;
  logic               dbz_q, dbz_d;
`ifdef DIV32_SIGNED_EN
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dvd_neg, dvs_neg;
`endif

  logic [WIDTH-1:0]   dvd_mag, dvs_mag;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic               accept;

`ifdef DIV32_SIGNED_EN
  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // FIN also accepts a new request so back-to-back divides have no bubble.
  assign accept = start && (state_q != RUN);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (quo_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    remd_d  = remd_q;
    dbz_d   = dbz_q;
`ifdef DIV32_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif

    case (state_q)
      RUN: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        if (count_q == '0) begin
          state_d = FIN;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      FIN: begin
        done_d  = 1'b1;
        dbz_d   = zero_q;
        state_d = IDLE;
        if (zero_q) begin
          quot_d = DIV_ZERO_Q;
          remd_d = dvd_q;
        end else begin
`ifdef DIV32_SIGNED_EN
          quot_d = qneg_q ? -quo_q : quo_q;
          remd_d = rneg_q ? -rem_q : rem_q;
`else
          quot_d = quo_q;
          remd_d = rem_q;
`endif
        end
      end
      default: ;
    endcase

    // The finishing result owns div_by_zero; a start in FIN must not clear it.
    if (accept) begin
      state_d = (divisor == '0) ? FIN : RUN;
      count_d = CNT_W'(WIDTH - 1);
      rem_d   = '0;
      quo_d   = dvd_mag;
      dvs_d   = dvs_mag;
      dvd_d   = dividend;
      zero_d  = (divisor == '0);
      if (state_q != FIN) begin
        dbz_d = 1'b0;
      end
`ifdef DIV32_SIGNED_EN
      qneg_d  = dvd_neg ^ dvs_neg;
      rneg_d  = dvd_neg;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV32_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      dbz_q   <= dbz_d;
`ifdef DIV32_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// Directed scoreboard bench for div32_seq; define DIV32_SIGNED_EN to add signed cases.
module tb_div32_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
`ifdef DIV32_SIGNED_EN
  logic         is_signed = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  always #5 clk = ~clk;

  div32_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV32_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
    int           busy_n;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request one edge ahead; on return we sit just after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input int lat, input int bn);
    exp_t e;
    e.a = a; e.b = b; e.sgn = s; e.q = eq; e.r = er; e.z = ez; e.lat = lat; e.busy_n = bn;
    sb.push_back(e);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef DIV32_SIGNED_EN
    is_signed = s;
`endif
    tick();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic check_done_now();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard: observed done with empty queue, expected no done");
      return;
    end
    e = sb.pop_front();
    chk("quotient", quotient, e.q);
    chk("remainder", remainder, e.r);
    chk("div_by_zero", div_by_zero, e.z);
    $display("txn a=0x%08h b=0x%08h signed=%0b -> q=0x%08h r=0x%08h dbz=%0b",
             e.a, e.b, e.sgn, quotient, remainder, div_by_zero);
  endtask

  task automatic wait_done();
    exp_t e;
    int   k;
    int   bc;
    int   lim;
    k  = 0;
    bc = 0;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard: observed wait with empty queue, expected a pending request");
      return;
    end
    e   = sb[0];
    lim = e.lat + 10;
    forever begin
      if (busy === 1'b1) bc++;
      if (k >= lim) break;
      tick();
      k++;
      if (done === 1'b1) break;
    end
    chk("done_latency", k, e.lat);
    if (e.busy_n >= 0) chk("busy_cycles", bc, e.busy_n);
    if (done === 1'b1) check_done_now();
    else void'(sb.pop_front());
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           nd;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    // Basic
    launch(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 32);
    wait_done();
    tick();
    chk("done_pulse_width", done, 0);

    // Boundaries
    launch(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 32);
    wait_done();
    launch(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 33, 32);
    wait_done();

    // Divide by zero, then the flag clears on the next start while results hold
    launch(32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1, 0);
    wait_done();
    tick();
    chk("dbz_hold", div_by_zero, 1);
    launch(32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 1'b0, 33, 32);
    chk("dbz_clear_on_start", div_by_zero, 0);
    chk("quotient_hold", quotient, 32'hFFFF_FFFF);
    wait_done();

    // Random unsigned operands against the language's own divide
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i[0]) ? $urandom : W'($urandom_range(1, 1000));
      if (rb == '0) rb = 32'd3;
      launch(ra, rb, 1'b0, ra / rb, ra % rb, 1'b0, 33, 32);
      wait_done();
    end

    // Start while busy is ignored; start in FIN is accepted back-to-back
    launch(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 33, 32);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 9) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end
      if (k == 10) start = 1'b0;
    end
    chk("fin_busy", busy, 0);
    chk("fin_no_done_yet", done, 0);
    sb.push_back('{a: 32'd9, b: 32'd3, sgn: 1'b0, q: 32'd3, r: 32'd0, z: 1'b0, lat: 33, busy_n: 32});
    start    = 1'b1;
    dividend = 32'd9;
    divisor  = 32'd3;
    tick();
    start    = 1'b0;
    chk("b2b_first_done", done, 1);
    if (done === 1'b1) check_done_now();
    else void'(sb.pop_front());
    chk("b2b_accepted_busy", busy, 1);
    wait_done();

    // Reset in the middle of a division
    launch(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0, 33, 32);
    repeat (15) tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_quotient", quotient, 0);
    chk("arst_remainder", remainder, 0);
    chk("arst_dbz", div_by_zero, 0);
    #2;
    rst_n = 1'b1;
    sb.delete();
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done === 1'b1) nd++;
    end
    chk("no_done_after_reset", nd, 0);
    chk("idle_after_reset", busy, 0);

    launch(32'd81, 32'd9, 1'b0, 32'd9, 32'd0, 1'b0, 33, 32);
    wait_done();

`ifdef DIV32_SIGNED_EN
    launch(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 32);
    wait_done();
    launch(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 32);
    wait_done();
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, 32);
    wait_done();
    launch(32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, 0);
    wait_done();
    launch(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, 32);
    wait_done();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
